// File: rtl/cruise_speed_driver_pkg.sv
// Shared types for the cruise speed driver: FSM states and the two-bit
// {enable, mode} command presented to the loadable up/down speed counter.
package cruise_speed_driver_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic enable;
    logic mode;
  } cmd_t;

  // The counter loads on every {enable=0, mode=1} clock, so CMD_LOAD must
  // only ever be held for the single LOAD cycle.
  localparam cmd_t CMD_UP   = 2'b11;
  localparam cmd_t CMD_DOWN = 2'b10;
  localparam cmd_t CMD_LOAD = 2'b01;
  localparam cmd_t CMD_IDLE = 2'b00;

endpackage

// File: rtl/cruise_btn_edge.sv
// Registered rising-edge detector for a bank of level buttons; each rise
// output is a one-clock pulse one clock after the button goes high.
module cruise_btn_edge #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [N-1:0] btn,
  output logic [N-1:0] rise
);

  logic [N-1:0] btn_q;

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      btn_q <= '0;
      rise  <= '0;
    end else begin
      btn_q <= btn;
      rise  <= btn & ~btn_q;
    end
  end

endmodule

// File: rtl/cruise_speed_driver.sv
// Cruise-control command driver: holds the target speed and steers the
// speed counter toward it with paced UP/DOWN pulses or a one-cycle LOAD.
module cruise_speed_driver #(
  parameter int W        = 3,
  parameter int STEP_DIV = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         set_btn,
  input  logic         resume_btn,
  input  logic         accel_btn,
  input  logic         decel_btn,
  input  logic         brake,
  input  logic [W-1:0] cur_speed,
  output logic         cnt_enable,
  output logic         cnt_mode,
  output logic [W-1:0] cnt_load,
  output logic         engaged,
  output logic [W-1:0] target
);

  import cruise_speed_driver_pkg::*;

  localparam int             PW        = $clog2(STEP_DIV);
  localparam logic [PW-1:0]  PACE_LAST = PW'(STEP_DIV - 1);
  localparam logic [W-1:0]   SPEED_MAX = '1;

  state_t        state;
  cmd_t          cmd;
  logic [PW-1:0] pace;
  logic [1:0]    rise;
  logic          set_rise;
  logic          resume_rise;
  logic          pace_wrap;
  logic [W-1:0]  stepped;
  logic [W-1:0]  hold_target;
  cmd_t          hold_cmd;

  cruise_btn_edge #(.N(2)) u_btn_edge (
    .clk   (clk),
    .clear (clear),
    .btn   ({resume_btn, set_btn}),
    .rise  (rise)
  );

  assign set_rise    = rise[0];
  assign resume_rise = rise[1];
  assign pace_wrap   = (pace == PACE_LAST);
  assign cnt_enable  = cmd.enable;
  assign cnt_mode    = cmd.mode;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    stepped = target;
    if (accel_btn && target != SPEED_MAX) begin
      stepped = target + 1'b1;
    end else if (decel_btn && target != '0) begin
      stepped = target - 1'b1;
    end
  end

  // A set edge re-captures the current speed and overrides any step on the
  // same clock; comparing against the captured value then yields IDLE.
  always_comb begin
    hold_target = target;
    hold_cmd    = CMD_IDLE;
    if (set_rise) begin
      hold_target = cur_speed;
    end else if (pace_wrap) begin
      hold_target = stepped;
    end
    if (pace_wrap) begin
      if (cur_speed < hold_target && cur_speed != SPEED_MAX) begin
        hold_cmd = CMD_UP;
      end else if (cur_speed > hold_target && cur_speed != '0) begin
        hold_cmd = CMD_DOWN;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= ST_OFF;
      cmd      <= CMD_IDLE;
      pace     <= '0;
      cnt_load <= '0;
      engaged  <= 1'b0;
      target   <= '0;
    end else begin
      cmd <= CMD_IDLE;
      if (brake) begin
        // Target is kept so a later resume can reload it.
        state   <= ST_OFF;
        engaged <= 1'b0;
        pace    <= '0;
      end else begin
        case (state)
          ST_OFF: begin
            engaged <= 1'b0;
            pace    <= '0;
            if (set_rise) begin
              target  <= cur_speed;
              engaged <= 1'b1;
              state   <= ST_HOLD;
            end else if (resume_rise) begin
              cnt_load <= target;
              cmd      <= CMD_LOAD;
              state    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            engaged <= 1'b1;
            pace    <= '0;
            state   <= ST_HOLD;
          end
          ST_HOLD: begin
            engaged <= 1'b1;
            target  <= hold_target;
            cmd     <= hold_cmd;
            pace    <= pace_wrap ? '0 : pace + 1'b1;
          end
          default: begin
            engaged <= 1'b0;
            pace    <= '0;
            state   <= ST_OFF;
          end
        endcase
      end
    end
  end

endmodule
